// File: rtl/fp_add_pkg.sv
// Shared types, constants and classification helpers for the binary32 FADD/FSUB datapath.
package fp_add_pkg;

  localparam int MANT_W  = 23;
  localparam int SIG_W   = 24;
  localparam int ALIGN_W = 27;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    SUBNORM = 3'd1,
    NORM    = 3'd2,
    INF     = 3'd3,
    QNAN    = 3'd4,
    SNAN    = 3'd5
  } fp_class_e;

  function automatic fp_class_e fp_classify(input fp32_t f);
    fp_class_e c;
    if (f.exp == 8'h00) begin
      if (f.man == 23'd0) c = ZERO;
      else                c = SUBNORM;
    end else if (f.exp == EXP_MAX) begin
      if (f.man == 23'd0)   c = INF;
      else if (f.man[22])   c = QNAN;
      else                  c = SNAN;
    end else begin
      c = NORM;
    end
    return c;
  endfunction

  // Subnormals share the scale of exponent 1.
  function automatic logic [7:0] fp_eff_exp(input logic [7:0] e);
    return (e == 8'h00) ? 8'h01 : e;
  endfunction

  function automatic logic [SIG_W-1:0] fp_sig(input fp32_t f);
    return {(f.exp != 8'h00), f.man};
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Saturating 27-bit right shifter for significand alignment.
// Sticky collection is built only when FP_ALIGN_STICKY_EN is defined.
module fp_align_shifter
  import fp_add_pkg::*;
#(
  parameter int SHIFT_SAT = 27
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic [7:0]       i_shamt,
  output logic [SIG_W-1:0] o_sig,
  output logic [1:0]       o_gr,
  output logic             o_sticky
);

  localparam logic [7:0] SAT_AMT = 8'(SHIFT_SAT);

  logic [ALIGN_W-1:0] w_val;
  logic [ALIGN_W-1:0] w_res;
  logic [7:0]         w_amt;

  assign w_val = {i_sig, 3'b000};
  assign w_amt = (i_shamt >= SAT_AMT) ? SAT_AMT : i_shamt;
  assign w_res = w_val >> w_amt;

  assign o_sig = w_res[ALIGN_W-1:3];
  assign o_gr  = w_res[2:1];

`ifdef FP_ALIGN_STICKY_EN
  logic [ALIGN_W-1:0] w_lost_mask;

  // Ones over every bit position that falls off the bottom for this shift.
  assign w_lost_mask = ~({ALIGN_W{1'b1}} << w_amt);
  assign o_sticky    = w_res[0] | (|(w_val & w_lost_mask));
`else
  logic w_unused_lsb;

  assign w_unused_lsb = w_res[0];
  assign o_sticky     = 1'b0;
`endif

endmodule

// File: rtl/fp_extract_align_pipe.sv
// Two-stage unpack/swap/align front end of the binary32 adder.
// Optional sticky collection in alignment: define FP_ALIGN_STICKY_EN.
module fp_extract_align_pipe
  import fp_add_pkg::*;
#(
  parameter int SHIFT_SAT = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign1,
  output logic        sign2,
  output logic [23:0] mant_big,
  output logic [23:0] mant_small,
  output logic [2:0]  grs,
  output logic [7:0]  exp_res,
  output logic        zero,
  output logic        special,
  output logic        nan
);

  fp32_t      w_a;
  fp32_t      w_b;
  fp32_t      w_b_eff;
  fp32_t      w_big;
  fp32_t      w_small;
  fp_class_e  w_cls_a;
  fp_class_e  w_cls_b;
  logic       w_eff_sign_b;
  logic       w_swap;
  logic [7:0] w_d;
  logic       w_zero;
  logic       w_special;
  logic       w_nan;
  logic       w_ready2;
  logic       w_load1;
  logic       w_load2;

  logic [SIG_W-1:0] w_align_sig;
  logic [1:0]       w_align_gr;
  logic             w_align_sticky;

  logic             r_v1;
  logic             r_s1_sign1;
  logic             r_s1_sign2;
  logic [SIG_W-1:0] r_s1_mant_big;
  logic [SIG_W-1:0] r_s1_mant_small;
  logic [7:0]       r_s1_exp_big;
  logic [7:0]       r_s1_d;
  logic             r_s1_zero;
  logic             r_s1_special;
  logic             r_s1_nan;

  logic             r_v2;
  logic             r_sign1;
  logic             r_sign2;
  logic [SIG_W-1:0] r_mant_big;
  logic [SIG_W-1:0] r_mant_small;
  logic [2:0]       r_grs;
  logic [7:0]       r_exp_res;
  logic             r_zero;
  logic             r_special;
  logic             r_nan;

  assign w_a          = op_a;
  assign w_b          = op_b;
  assign w_eff_sign_b = w_b.sign ^ sub;
  assign w_b_eff      = {w_eff_sign_b, w_b.exp, w_b.man};

  // Magnitude compare on {exp, man}; equal magnitudes keep A on top.
  assign w_swap = ({w_b.exp, w_b.man} > {w_a.exp, w_a.man});

  always_comb begin
    w_big   = w_a;
    w_small = w_b_eff;
    if (w_swap) begin
      w_big   = w_b_eff;
      w_small = w_a;
    end else begin
      w_big   = w_a;
      w_small = w_b_eff;
    end
  end

  assign w_d = fp_eff_exp(w_big.exp) - fp_eff_exp(w_small.exp);

  assign w_cls_a   = fp_classify(w_a);
  assign w_cls_b   = fp_classify(w_b);
  assign w_zero    = (w_cls_a == ZERO) || (w_cls_b == ZERO);
  assign w_special = (w_a.exp == EXP_MAX) || (w_b.exp == EXP_MAX);
  // Infinities of opposite effective sign cancel into NaN.
  assign w_nan     = (w_cls_a == QNAN) || (w_cls_a == SNAN) ||
                     (w_cls_b == QNAN) || (w_cls_b == SNAN) ||
                     ((w_cls_a == INF) && (w_cls_b == INF) && (w_a.sign != w_eff_sign_b));

  assign w_ready2 = !r_v2 || out_ready;
  assign in_ready = !r_v1 || w_ready2;
  assign w_load1  = in_valid && in_ready;
  assign w_load2  = r_v1 && w_ready2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1            <= 1'b0;
      r_s1_sign1      <= 1'b0;
      r_s1_sign2      <= 1'b0;
      r_s1_mant_big   <= 24'h000000;
      r_s1_mant_small <= 24'h000000;
      r_s1_exp_big    <= 8'h00;
      r_s1_d          <= 8'h00;
      r_s1_zero       <= 1'b0;
      r_s1_special    <= 1'b0;
      r_s1_nan        <= 1'b0;
    end else begin
      if (in_ready) begin
        r_v1 <= in_valid;
      end
      if (w_load1) begin
        r_s1_sign1      <= w_big.sign;
        r_s1_sign2      <= w_small.sign;
        r_s1_mant_big   <= fp_sig(w_big);
        r_s1_mant_small <= fp_sig(w_small);
        r_s1_exp_big    <= w_big.exp;
        r_s1_d          <= w_d;
        r_s1_zero       <= w_zero;
        r_s1_special    <= w_special;
        r_s1_nan        <= w_nan;
      end
    end
  end

  fp_align_shifter #(
    .SHIFT_SAT (SHIFT_SAT)
  ) u_align (
    .i_sig    (r_s1_mant_small),
    .i_shamt  (r_s1_d),
    .o_sig    (w_align_sig),
    .o_gr     (w_align_gr),
    .o_sticky (w_align_sticky)
  );

  // Stage 2 holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2         <= 1'b0;
      r_sign1      <= 1'b0;
      r_sign2      <= 1'b0;
      r_mant_big   <= 24'h000000;
      r_mant_small <= 24'h000000;
      r_grs        <= 3'b000;
      r_exp_res    <= 8'h00;
      r_zero       <= 1'b0;
      r_special    <= 1'b0;
      r_nan        <= 1'b0;
    end else begin
      if (w_ready2) begin
        r_v2 <= r_v1;
      end
      if (w_load2) begin
        r_sign1      <= r_s1_sign1;
        r_sign2      <= r_s1_sign2;
        r_mant_big   <= r_s1_mant_big;
        r_mant_small <= w_align_sig;
        r_grs        <= {w_align_gr, w_align_sticky};
        r_exp_res    <= r_s1_exp_big;
        r_zero       <= r_s1_zero;
        r_special    <= r_s1_special;
        r_nan        <= r_s1_nan;
      end
    end
  end

  assign out_valid  = r_v2;
  assign sign1      = r_sign1;
  assign sign2      = r_sign2;
  assign mant_big   = r_mant_big;
  assign mant_small = r_mant_small;
  assign grs        = r_grs;
  assign exp_res    = r_exp_res;
  assign zero       = r_zero;
  assign special    = r_special;
  assign nan        = r_nan;

endmodule

// File: tb/tb_fp_extract_align_pipe.sv
// Randomized self-checking bench for fp_extract_align_pipe against an arithmetic reference model.
module tb_fp_extract_align_pipe;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] v;
    logic        sp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign1, sign2, zero, special, nan;
  logic [23:0] mant_big, mant_small;
  logic [2:0]  grs;
  logic [7:0]  exp_res;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops = 0;

  exp_t        sb_q[$];
  logic        stall_prev = 1'b0;
  logic [63:0] held = 64'h0;
  logic [63:0] obs;

  fp_extract_align_pipe #(.SHIFT_SAT(27)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sign1(sign1), .sign2(sign2), .mant_big(mant_big), .mant_small(mant_small),
    .grs(grs), .exp_res(exp_res), .zero(zero), .special(special), .nan(nan)
  );

  always #5 clk = ~clk;

  assign obs = {sign1, sign2, mant_big, mant_small, grs, exp_res, zero, special, nan};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: order by magnitude, scale the smaller significand by 8 and divide by 2^d.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   r;
    logic   sa, sb, sbig, ssml, zr, sp, nn, lost;
    int     ea, eb, ebig, esml, d;
    longint ma, mb, mbig, msml, sig_big, sig_sml, wide, shifted;
    logic [2:0] g;
    sa = a[31];
    sb = b[31] ^ s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    if (b[30:0] > a[30:0]) begin
      sbig = sb; ebig = eb; mbig = mb; ssml = sa; esml = ea; msml = ma;
    end else begin
      sbig = sa; ebig = ea; mbig = ma; ssml = sb; esml = eb; msml = mb;
    end
    sig_big = (ebig != 0) ? mbig + longint'(8388608) : mbig;
    sig_sml = (esml != 0) ? msml + longint'(8388608) : msml;
    d = ((ebig == 0) ? 1 : ebig) - ((esml == 0) ? 1 : esml);
    wide = sig_sml * 8;
    if (d >= 27) begin
      shifted = 0;
      lost = (wide != 0);
    end else begin
      shifted = wide >> d;
      lost = ((wide % (longint'(1) << d)) != 0);
    end
    g = shifted[2:0];
    g[0] = STICKY_ON ? (g[0] | lost) : 1'b0;
    zr = (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
    sp = (ea == 255) || (eb == 255);
    nn = (ea == 255 && ma != 0) || (eb == 255 && mb != 0) ||
         (ea == 255 && eb == 255 && ma == 0 && mb == 0 && sa != sb);
    r.v  = {sbig, ssml, 24'(sig_big), 24'(shifted >> 3), g, 8'(ebig), zr, sp, nn};
    r.sp = sp;
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    logic [31:0] v;
    int e;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v[30:0] = 31'd0;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(1, 2));
      default: begin
        e = base + int'($urandom_range(0, 64)) - 32;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
      end
    endcase
    return v;
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("hold_valid", 64'(out_valid), 64'd1);
          check_eq("hold_data", obs, held);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = sb_q.pop_front();
            n_pops++;
            if (e.sp) check_eq("out_flags", 64'(obs[2:0]), 64'(e.v[2:0]));
            else      check_eq("out_data", obs, e.v);
          end
        end
        if (in_valid && in_ready) sb_q.push_back(model(op_a, op_b, sub));
        stall_prev = out_valid && !out_ready;
        held = obs;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic s);
    in_valid = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("lat_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int base;
    int pop_base;
    logic [2:0] g30, g26;
    g30 = STICKY_ON ? 3'b001 : 3'b000;
    g26 = STICKY_ON ? 3'b001 : 3'b000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", obs, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);

    out_ready = 1'b1;
    send1(32'h3F800000, 32'h3F000000, 1'b1);
    check_eq("sub_basic", obs, {1'b0, 1'b1, 24'h800000, 24'h400000, 3'b000, 8'h7F, 1'b0, 1'b0, 1'b0});
    send1(32'h3F000000, 32'hBF800000, 1'b0);
    check_eq("swap", obs, {1'b1, 1'b0, 24'h800000, 24'h400000, 3'b000, 8'h7F, 1'b0, 1'b0, 1'b0});
    send1(32'h3F800000, 32'h30800000, 1'b0);
    check_eq("sat_d30", obs, {1'b0, 1'b0, 24'h800000, 24'h000000, g30, 8'h7F, 1'b0, 1'b0, 1'b0});
    send1(32'h3F800000, 32'h32FFFFFF, 1'b0);
    check_eq("d26", obs, {1'b0, 1'b0, 24'h800000, 24'h000000, g26, 8'h7F, 1'b0, 1'b0, 1'b0});
    send1(32'h7F800000, 32'h7F800000, 1'b1);
    check_eq("inf_inf", 64'(obs[2:0]), 64'(3'b011));
    send1(32'h00000000, 32'h3F800000, 1'b0);
    check_eq("zero_op", obs, {1'b0, 1'b0, 24'h800000, 24'h000000, 3'b000, 8'h7F, 1'b1, 1'b0, 1'b0});
    send1(32'h00000001, 32'h00000001, 1'b0);
    check_eq("subnorm_tie", obs, {1'b0, 1'b0, 24'h000001, 24'h000001, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    in_valid = 1'b1; op_a = rnd_op(127); op_b = rnd_op(127); sub = 1'b0;
    check_eq("bp_ready0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    op_a = rnd_op(100); op_b = rnd_op(100); sub = 1'b1;
    check_eq("bp_ready1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    op_a = rnd_op(60); op_b = rnd_op(60); sub = 1'b0;
    check_eq("bp_ready_drop", 64'(in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check_eq("bp_ready_held", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pop_base = n_pops;
    @(posedge clk); #1;
    op_a = rnd_op(200); op_b = rnd_op(200); sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_drain4", 64'(n_pops - pop_base), 64'd4);
    check_eq("bp_empty", 64'(sb_q.size()), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      base = int'($urandom_range(1, 254));
      in_valid = ($urandom_range(0, 9) < 7);
      op_a = rnd_op(base);
      op_b = ($urandom_range(0, 15) == 0) ? op_a : rnd_op(base);
      sub = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);

    // Reset while both stages hold data: everything in flight is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h40000000; sub = 1'b0;
    @(posedge clk); #1;
    op_a = 32'h41200000; op_b = 32'h3F000000;
    @(posedge clk); #1;
    check_eq("pre_rst_full", 64'({out_valid, in_ready}), 64'(2'b10));
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_data", obs, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("no_stale", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
